taliesin_alu_seq: RTL and testbench

Parametrised, handshaked successor to the Taliesin combinational ALU. It registers every result and flag and adds iterative unsigned multiply, divide and remainder, an XOR op, and a full N/Z/C/V condition nibble. It sits between the decode/operand-read stage and writeback, and uses valid/ready on both sides so multi-cycle ops stall the pipeline cleanly.

---
 rtl/taliesin_alu_seq_if.sv | 26 ++
 rtl/taliesin_alu_seq.sv | 190 +++++++++++++++++++
 tb/tb_taliesin_alu_seq.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/taliesin_alu_seq_if.sv
// Valid/ready bundle for the sequential Taliesin ALU.
// master drives operations and out_ready; slave is the ALU.
interface taliesin_alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [3:0]       cr_out;
  logic             busy;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, cr_out, busy
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, cr_out, busy
  );
endinterface

// File: rtl/taliesin_alu_seq.sv
// Handshaked ALU: registered single-cycle ops plus
// iterative unsigned MUL/DIVU/REMU, N/Z/C/V flags.
module taliesin_alu_seq #(
  parameter int WIDTH = 32
) (
  input logic              clk,
  input logic              reset_n,
  taliesin_alu_seq_if.slave io
);
  localparam int SW = $clog2(WIDTH);
  localparam int M  = WIDTH - 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [3:0]       cr_q, cr_d;

  logic accept;

  assign io.in_ready  = (state_q == S_IDLE)
                      | ((state_q == S_DONE) & io.out_ready);
  assign accept       = io.in_valid & io.in_ready;
  assign io.out_valid = (state_q == S_DONE);
  assign io.busy      = (state_q == S_MUL) | (state_q == S_DIV);
  assign io.result    = res_q;
  assign io.cr_out    = cr_q;

  logic [WIDTH-1:0]        s_res;
  logic                    s_c;
  logic                    s_v;
  logic [WIDTH:0]          sum;
  logic [WIDTH:0]          dif;
  logic [WIDTH:0]          shl;
  logic [WIDTH:0]          shr;
  logic signed [WIDTH:0]   sar;
  logic [SW-1:0]           sh;
  logic                    big;

  // Shifts use one guard bit so the last bit shifted out falls into it.
  always_comb begin
    sh    = io.b[SW-1:0];
    big   = |io.b[WIDTH-1:SW];
    sum   = {1'b0, io.a} + {1'b0, io.b};
    dif   = {1'b0, io.a} - {1'b0, io.b};
    shl   = {1'b0, io.a} << sh;
    shr   = {io.a, 1'b0} >> sh;
    sar   = $signed({io.a, 1'b0}) >>> sh;
    s_res = '0;
    s_c   = 1'b0;
    s_v   = 1'b0;
    unique case (io.op)
      4'd0: begin
        s_res = sum[M:0];
        s_c   = sum[WIDTH];
        s_v   = (io.a[M] == io.b[M]) & (sum[M] != io.a[M]);
      end
      4'd1: begin
        s_res = sum[M:0];
        s_c   = sum[WIDTH];
      end
      4'd2, 4'd9: begin
        s_res = dif[M:0];
        s_c   = ~dif[WIDTH];
        s_v   = (io.a[M] != io.b[M]) & (dif[M] != io.a[M]);
      end
      4'd3:  s_res = io.a | io.b;
      4'd4:  s_res = io.a & io.b;
      4'd5:  s_res = ~io.a;
      4'd6: begin
        s_res = big ? '0 : shl[M:0];
        s_c   = ~big & shl[WIDTH];
      end
      4'd7: begin
        s_res = big ? '0 : shr[WIDTH:1];
        s_c   = ~big & shr[0];
      end
      4'd8: begin
        s_res = big ? {WIDTH{io.a[M]}} : sar[WIDTH:1];
        s_c   = ~big & sar[0];
      end
      4'd10: s_res = io.a;
      4'd11: s_res = io.a ^ io.b;
      default: s_res = '0;
    endcase
  end

  logic [WIDTH-1:0] mul_acc;
  logic [WIDTH:0]   rsh;
  logic             ge;
  logic [WIDTH-1:0] rnext;
  logic [WIDTH-1:0] qnext;
  logic [WIDTH-1:0] dres;

  // x holds multiplicand or dividend/quotient; y multiplier or divisor.
  always_comb begin
    mul_acc = acc_q + (y_q[0] ? x_q : '0);
    rsh     = {acc_q, x_q[M]};
    ge      = rsh >= {1'b0, y_q};
    rnext   = ge ? rsh[M:0] - y_q : rsh[M:0];
    qnext   = {x_q[WIDTH-2:0], ge};
    dres    = (op_q == 4'd14) ? rnext : qnext;
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    x_d     = x_q;
    y_d     = y_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    cr_d    = cr_q;
    unique case (state_q)
      S_MUL: begin
        acc_d = mul_acc;
        x_d   = x_q << 1;
        y_d   = y_q >> 1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = S_DONE;
          res_d   = mul_acc;
          cr_d    = {mul_acc[M], mul_acc == '0, 2'b00};
        end
      end
      S_DIV: begin
        acc_d = rnext;
        x_d   = qnext;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = S_DONE;
          res_d   = dres;
          cr_d    = {dres[M], dres == '0, 1'b0, y_q == '0};
        end
      end
      S_DONE: begin
        if (io.out_ready) state_d = S_IDLE;
      end
      default: ;
    endcase
    if (accept) begin
      op_d  = io.op;
      x_d   = io.a;
      y_d   = io.b;
      acc_d = '0;
      cnt_d = '1;
      unique case (io.op)
        4'd12:        state_d = S_MUL;
        4'd13, 4'd14: state_d = S_DIV;
        default: begin
          state_d = S_DONE;
          res_d   = s_res;
          cr_d    = {s_res[M], s_res == '0, s_c, s_v};
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      cr_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      x_q     <= x_d;
      y_q     <= y_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      cr_q    <= cr_d;
    end
  end
endmodule

// File: tb/tb_taliesin_alu_seq.sv
// Directed bench for taliesin_alu_seq at WIDTH=32 and WIDTH=8.
// Each test task drives its scenario and checks inline.
module tb_taliesin_alu_seq;
  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  taliesin_alu_seq_if #(.WIDTH(32)) io32 ();
  taliesin_alu_seq_if #(.WIDTH(8))  io8 ();

  taliesin_alu_seq #(.WIDTH(32)) dut32 (
    .clk     (clk),
    .reset_n (reset_n),
    .io      (io32)
  );

  taliesin_alu_seq #(.WIDTH(8)) dut8 (
    .clk     (clk),
    .reset_n (reset_n),
    .io      (io8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive32(input logic [3:0] op,
                         input logic [31:0] a,
                         input logic [31:0] b);
    io32.op       = op;
    io32.a        = a;
    io32.b        = b;
    io32.in_valid = 1'b1;
    @(posedge clk);
    #1;
    io32.in_valid = 1'b0;
  endtask

  task automatic run_multi32(input logic [3:0] op,
                             input logic [31:0] a,
                             input logic [31:0] b,
                             output int cyc,
                             output int busy_n);
    drive32(op, a, b);
    cyc    = 0;
    busy_n = 0;
    while (!io32.out_valid && cyc < 40) begin
      if (io32.busy) busy_n++;
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  function automatic void ref_alu(input int w,
                                  input logic [3:0] op,
                                  input logic [63:0] a,
                                  input logic [63:0] b,
                                  output logic [63:0] r,
                                  output logic [3:0] cr);
    logic [63:0] mask;
    logic [63:0] full;
    logic sa, sb, sr, c, v;
    mask = (64'd1 << w) - 64'd1;
    sa   = a[w-1];
    sb   = b[w-1];
    c    = 1'b0;
    v    = 1'b0;
    r    = 64'd0;
    case (op)
      4'd0, 4'd1: begin
        full = a + b;
        r    = full & mask;
        c    = full[w];
        sr   = r[w-1];
        if (op == 4'd0) v = (sa == sb) && (sr != sa);
      end
      4'd2, 4'd9: begin
        r  = (a - b) & mask;
        c  = (a >= b);
        sr = r[w-1];
        v  = (sa != sb) && (sr != sa);
      end
      4'd3:  r = a | b;
      4'd4:  r = a & b;
      4'd5:  r = ~a & mask;
      4'd6: begin
        if (b >= 64'(w)) r = 64'd0;
        else if (b == 64'd0) r = a;
        else begin
          r = (a << b) & mask;
          c = a[w - int'(b)];
        end
      end
      4'd7: begin
        if (b >= 64'(w)) r = 64'd0;
        else if (b == 64'd0) r = a;
        else begin
          r = a >> b;
          c = a[int'(b) - 1];
        end
      end
      4'd8: begin
        if (b >= 64'(w)) r = sa ? mask : 64'd0;
        else if (b == 64'd0) r = a;
        else begin
          r = (a >> b) | (sa ? (mask & ~(mask >> b)) : 64'd0);
          c = a[int'(b) - 1];
        end
      end
      4'd10: r = a;
      4'd11: r = a ^ b;
      default: r = 64'd0;
    endcase
    cr = {r[w-1], r == 64'd0, c, v};
  endfunction

  task automatic test_reset;
    reset_n        = 1'b0;
    io32.in_valid  = 1'b0;
    io32.out_ready = 1'b1;
    io32.op        = '0;
    io32.a         = '0;
    io32.b         = '0;
    io8.in_valid   = 1'b0;
    io8.out_ready  = 1'b1;
    io8.op         = '0;
    io8.a          = '0;
    io8.b          = '0;
    #12;
    checks++;
    if ({io32.in_ready, io32.out_valid, io32.busy, io32.result, io32.cr_out}
        !== {3'b100, 32'd0, 4'd0}) begin
      errors++;
      $display("FAIL reset32 got rdy=%b ov=%b busy=%b res=%h cr=%b exp 1/0/0/0/0",
               io32.in_ready, io32.out_valid, io32.busy, io32.result, io32.cr_out);
    end
    checks++;
    if ({io8.in_ready, io8.out_valid, io8.busy, io8.result, io8.cr_out}
        !== {3'b100, 8'd0, 4'd0}) begin
      errors++;
      $display("FAIL reset8 got rdy=%b ov=%b busy=%b res=%h cr=%b exp 1/0/0/0/0",
               io8.in_ready, io8.out_valid, io8.busy, io8.result, io8.cr_out);
    end
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_arith;
    drive32(4'd0, 32'h7FFF_FFFF, 32'h0000_0001);
    checks++;
    if ({io32.out_valid, io32.result, io32.cr_out} !== {1'b1, 32'h8000_0000, 4'b1001}) begin
      errors++;
      $display("FAIL add_ovf got ov=%b %h cr=%b exp 1 80000000 1001",
               io32.out_valid, io32.result, io32.cr_out);
    end
    drive32(4'd2, 32'd5, 32'd7);
    checks++;
    if ({io32.out_valid, io32.result, io32.cr_out} !== {1'b1, 32'hFFFF_FFFE, 4'b1000}) begin
      errors++;
      $display("FAIL sub got ov=%b %h cr=%b exp 1 fffffffe 1000",
               io32.out_valid, io32.result, io32.cr_out);
    end
    drive32(4'd9, 32'd7, 32'd7);
    checks++;
    if ({io32.out_valid, io32.result, io32.cr_out} !== {1'b1, 32'd0, 4'b0110}) begin
      errors++;
      $display("FAIL cmp_eq got ov=%b %h cr=%b exp 1 00000000 0110",
               io32.out_valid, io32.result, io32.cr_out);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_shift;
    drive32(4'd7, 32'h8000_0000, 32'd31);
    checks++;
    if ({io32.result, io32.cr_out} !== {32'h0000_0001, 4'b0000}) begin
      errors++;
      $display("FAIL lsr31 got %h cr=%b exp 00000001 0000", io32.result, io32.cr_out);
    end
    drive32(4'd6, 32'h8000_0001, 32'd1);
    checks++;
    if ({io32.result, io32.cr_out} !== {32'h0000_0002, 4'b0010}) begin
      errors++;
      $display("FAIL lsl1 got %h cr=%b exp 00000002 0010", io32.result, io32.cr_out);
    end
    drive32(4'd8, 32'h8000_0000, 32'd40);
    checks++;
    if ({io32.result, io32.cr_out} !== {32'hFFFF_FFFF, 4'b1000}) begin
      errors++;
      $display("FAIL asr40 got %h cr=%b exp ffffffff 1000", io32.result, io32.cr_out);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_multi;
    int cyc;
    int bn;
    run_multi32(4'd12, 32'h0001_0000, 32'h0001_0000, cyc, bn);
    checks++;
    if (cyc !== 32 || bn !== 32) begin
      errors++;
      $display("FAIL mul_latency got edges=%0d busy=%0d exp 32 32", cyc, bn);
    end
    checks++;
    if ({io32.out_valid, io32.busy, io32.result, io32.cr_out} !== {2'b10, 32'd0, 4'b0100}) begin
      errors++;
      $display("FAIL mul_res got ov=%b busy=%b %h cr=%b exp 1 0 00000000 0100",
               io32.out_valid, io32.busy, io32.result, io32.cr_out);
    end
    run_multi32(4'd13, 32'd100, 32'd7, cyc, bn);
    checks++;
    if (cyc !== 32 || {io32.result, io32.cr_out} !== {32'd14, 4'b0000}) begin
      errors++;
      $display("FAIL divu got edges=%0d %h cr=%b exp 32 0000000e 0000",
               cyc, io32.result, io32.cr_out);
    end
    run_multi32(4'd14, 32'd100, 32'd7, cyc, bn);
    checks++;
    if (cyc !== 32 || {io32.result, io32.cr_out} !== {32'd2, 4'b0000}) begin
      errors++;
      $display("FAIL remu got edges=%0d %h cr=%b exp 32 00000002 0000",
               cyc, io32.result, io32.cr_out);
    end
    run_multi32(4'd13, 32'd5, 32'd0, cyc, bn);
    checks++;
    if (cyc !== 32 || {io32.result, io32.cr_out} !== {32'hFFFF_FFFF, 4'b1001}) begin
      errors++;
      $display("FAIL divu_zero got edges=%0d %h cr=%b exp 32 ffffffff 1001",
               cyc, io32.result, io32.cr_out);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure;
    io32.out_ready = 1'b0;
    drive32(4'd0, 32'd3, 32'd4);
    io32.op       = 4'd11;
    io32.a        = 32'h0000_F0F0;
    io32.b        = 32'h0000_0FF0;
    io32.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({io32.out_valid, io32.in_ready, io32.result, io32.cr_out}
          !== {2'b10, 32'd7, 4'b0000}) begin
        errors++;
        $display("FAIL stall%0d got ov=%b rdy=%b %h cr=%b exp 1 0 00000007 0000",
                 i, io32.out_valid, io32.in_ready, io32.result, io32.cr_out);
      end
    end
    io32.out_ready = 1'b1;
    #1;
    checks++;
    if (io32.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release_rdy got %b exp 1", io32.in_ready);
    end
    @(posedge clk);
    #1;
    io32.in_valid = 1'b0;
    checks++;
    if ({io32.out_valid, io32.result, io32.cr_out} !== {1'b1, 32'h0000_FF00, 4'b0000}) begin
      errors++;
      $display("FAIL release_xor got ov=%b %h cr=%b exp 1 0000ff00 0000",
               io32.out_valid, io32.result, io32.cr_out);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_mul;
    drive32(4'd12, 32'd3, 32'd5);
    repeat (10) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({io32.out_valid, io32.busy, io32.in_ready, io32.result, io32.cr_out}
        !== {3'b001, 32'd0, 4'd0}) begin
      errors++;
      $display("FAIL mid_reset got ov=%b busy=%b rdy=%b %h cr=%b exp 0 0 1 0 0",
               io32.out_valid, io32.busy, io32.in_ready, io32.result, io32.cr_out);
    end
    #2;
    reset_n = 1'b1;
    drive32(4'd0, 32'd1, 32'd1);
    checks++;
    if ({io32.out_valid, io32.result, io32.cr_out} !== {1'b1, 32'd2, 4'b0000}) begin
      errors++;
      $display("FAIL post_reset_add got ov=%b %h cr=%b exp 1 00000002 0000",
               io32.out_valid, io32.result, io32.cr_out);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back;
    logic [3:0]  op32, op8;
    logic [63:0] a32, b32, a8, b8;
    logic [63:0] r32, r8;
    logic [3:0]  c32, c8;
    io32.out_ready = 1'b1;
    io8.out_ready  = 1'b1;
    for (int i = 0; i < 16; i++) begin
      op32 = 4'($urandom_range(0, 12));
      if (op32 == 4'd12) op32 = 4'd15;
      op8 = 4'($urandom_range(0, 12));
      if (op8 == 4'd12) op8 = 4'd15;
      a32 = {32'd0, $urandom()};
      b32 = (op32 >= 4'd6 && op32 <= 4'd8) ? 64'($urandom_range(0, 36))
                                            : {32'd0, $urandom()};
      a8  = 64'($urandom_range(0, 255));
      b8  = (op8 >= 4'd6 && op8 <= 4'd8) ? 64'($urandom_range(0, 11))
                                          : 64'($urandom_range(0, 255));
      ref_alu(32, op32, a32, b32, r32, c32);
      ref_alu(8, op8, a8, b8, r8, c8);
      io32.op       = op32;
      io32.a        = a32[31:0];
      io32.b        = b32[31:0];
      io32.in_valid = 1'b1;
      io8.op        = op8;
      io8.a         = a8[7:0];
      io8.b         = b8[7:0];
      io8.in_valid  = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if ({io32.out_valid, io32.result, io32.cr_out} !== {1'b1, r32[31:0], c32}) begin
        errors++;
        $display("FAIL b2b32 step %0d op %0d a %h b %h got ov=%b %h cr=%b exp 1 %h %b",
                 i, op32, a32[31:0], b32[31:0], io32.out_valid, io32.result,
                 io32.cr_out, r32[31:0], c32);
      end
      checks++;
      if ({io8.out_valid, io8.result, io8.cr_out} !== {1'b1, r8[7:0], c8}) begin
        errors++;
        $display("FAIL b2b8 step %0d op %0d a %h b %h got ov=%b %h cr=%b exp 1 %h %b",
                 i, op8, a8[7:0], b8[7:0], io8.out_valid, io8.result,
                 io8.cr_out, r8[7:0], c8);
      end
    end
    io32.in_valid = 1'b0;
    io8.in_valid  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_arith();
    test_shift();
    test_multi();
    test_backpressure();
    test_reset_mid_mul();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
